// File: rtl/id_ex_if.sv
// id_ex_if: the bus between decode, the ID/EX register, and the forwarding sources.
// It groups the decode handshake, the EX-stage outputs and the EX/MEM and MEM/WB
// writeback taps.
// The ID_EX_PERF_CNT_EN macro adds the stall_cycles and flush_count counter outputs.
//
// Handshake: decode offers an instruction with id_valid. It transfers into the EX
// slot on a rising edge where id_valid and id_ready are both high and flush is low.
// id_ready is combinational and never depends on the EX outputs it produces. It is
// also high during flush, because the ID instruction is discarded in that cycle.
interface id_ex_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
);
    // decode side
    logic                  id_valid;
    logic                  id_ready;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic [XLEN-1:0]       id_rs1_data;
    logic [XLEN-1:0]       id_rs2_data;
    logic [XLEN-1:0]       id_imm;
    logic                  id_use_imm;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic [ALU_CTRL_W-1:0] id_alu_control;

    // pipeline control
    logic                  flush;
    logic                  ex_stall;

    // forwarding taps
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  mem_reg_write;
    logic [XLEN-1:0]       mem_result;
    logic [REG_ADDR_W-1:0] wb_rd_addr;
    logic                  wb_reg_write;
    logic [XLEN-1:0]       wb_result;

    // EX stage
    logic                  ex_valid;
    logic [XLEN-1:0]       ex_in_a;
    logic [XLEN-1:0]       ex_in_b;
    logic [ALU_CTRL_W-1:0] ex_alu_control;
    logic [XLEN-1:0]       ex_store_data;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_reg_write;
    logic                  ex_mem_read;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]           stall_cycles;
    logic [31:0]           flush_count;

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read,
               id_alu_control, flush, ex_stall,
               mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        output id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read,
               stall_cycles, flush_count
    );

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read,
               id_alu_control, flush, ex_stall,
               mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        input  id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read,
               stall_cycles, flush_count
    );
`else
    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read,
               id_alu_control, flush, ex_stall,
               mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        output id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read
    );

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_rd_addr, id_reg_write, id_mem_read,
               id_alu_control, flush, ex_stall,
               mem_rd_addr, mem_reg_write, mem_result,
               wb_rd_addr, wb_reg_write, wb_result,
        input  id_ready, ex_valid, ex_in_a, ex_in_b, ex_alu_control,
               ex_store_data, ex_rd_addr, ex_reg_write, ex_mem_read
    );
`endif

endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: the ID/EX pipeline register that feeds the EX-stage ALU.
// It captures the decoded operands and control. RAW hazards are resolved by
// forwarding from EX/MEM (highest priority) and MEM/WB, or by inserting a bubble
// when a load sits in EX and the instruction in ID reads the load's destination.
// Edge priority, highest first: flush, ex_stall, load-use bubble, accept, idle bubble.
// Defining ID_EX_PERF_CNT_EN adds the stall_cycles and flush_count counters.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = 4
) (
    input logic   clk,
    input logic   reset,
    id_ex_if.slave bus
);

    // EX slot contents. The data fields hold stale values across bubbles.
    logic                  valid_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [XLEN-1:0]       rs1_data_q;
    logic [XLEN-1:0]       rs2_data_q;
    logic [XLEN-1:0]       imm_q;
    logic                  use_imm_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic [ALU_CTRL_W-1:0] alu_control_q;

    logic                  load_use;
    logic                  ready;
    logic                  accept;
    logic [XLEN-1:0]       fwd_1;
    logic [XLEN-1:0]       fwd_2;

    // Load-use detection uses only registered EX fields. rs2 is compared even
    // for immediate forms, because a store still reads rs2 as its data.
    always_comb begin
        load_use = bus.id_valid & valid_q & mem_read_q &
                   (rd_addr_q != '0) &
                   ((rd_addr_q == bus.id_rs1_addr) | (rd_addr_q == bus.id_rs2_addr));
    end

    // Handshake decision in priority order. A flush discards the ID instruction,
    // so id_ready is high in that cycle while accept stays low.
    always_comb begin
        ready  = 1'b1;
        accept = 1'b0;
        if (bus.flush) begin
            ready = 1'b1;
        end else if (bus.ex_stall) begin
            ready = 1'b0;
        end else if (load_use) begin
            ready = 1'b0;
        end else begin
            ready  = 1'b1;
            accept = bus.id_valid;
        end
    end

    // Slot valid and the side-effecting controls.
    // A flush clears reg_write and mem_read so nothing downstream commits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else if (!bus.ex_stall) begin
            if (accept) begin
                valid_q     <= 1'b1;
                reg_write_q <= bus.id_reg_write;
                mem_read_q  <= bus.id_mem_read;
            end else begin
                valid_q     <= 1'b0;
            end
        end
    end

    // Datapath fields load only on accept and otherwise hold, including during bubbles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            use_imm_q     <= 1'b0;
            rd_addr_q     <= '0;
            alu_control_q <= '0;
        end else if (accept) begin
            rs1_addr_q    <= bus.id_rs1_addr;
            rs2_addr_q    <= bus.id_rs2_addr;
            rs1_data_q    <= bus.id_rs1_data;
            rs2_data_q    <= bus.id_rs2_data;
            imm_q         <= bus.id_imm;
            use_imm_q     <= bus.id_use_imm;
            rd_addr_q     <= bus.id_rd_addr;
            alu_control_q <= bus.id_alu_control;
        end
    end

    // rs1 forwarding: EX/MEM wins over MEM/WB. Register 0 is never forwarded.
    always_comb begin
        fwd_1 = rs1_data_q;
        if (bus.mem_reg_write && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == rs1_addr_q)) begin
            fwd_1 = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rs1_addr_q)) begin
            fwd_1 = bus.wb_result;
        end
    end

    // rs2 forwarding: same rule as rs1. It feeds both in_b and the store data.
    always_comb begin
        fwd_2 = rs2_data_q;
        if (bus.mem_reg_write && (bus.mem_rd_addr != '0) && (bus.mem_rd_addr == rs2_addr_q)) begin
            fwd_2 = bus.mem_result;
        end else if (bus.wb_reg_write && (bus.wb_rd_addr != '0) && (bus.wb_rd_addr == rs2_addr_q)) begin
            fwd_2 = bus.wb_result;
        end
    end

    assign bus.id_ready       = ready;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_in_a        = fwd_1;
    assign bus.ex_in_b        = use_imm_q ? imm_q : fwd_2;
    assign bus.ex_store_data  = fwd_2;
    assign bus.ex_alu_control = alu_control_q;
    assign bus.ex_rd_addr     = rd_addr_q;
    assign bus.ex_reg_write   = reg_write_q & valid_q;
    assign bus.ex_mem_read    = mem_read_q & valid_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Event counters. Both wrap naturally. A held stall without flush counts nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.flush) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
        end else if (!bus.ex_stall && load_use) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus a randomized run checked against a
// transaction-level model of the EX slot.
module tb_id_ex_stage;

    localparam int XLEN = 32;
    localparam int RA   = 5;
    localparam int AC   = 4;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_ex_if #(.XLEN(XLEN), .REG_ADDR_W(RA), .ALU_CTRL_W(AC)) bus ();

    id_ex_stage #(.XLEN(XLEN), .REG_ADDR_W(RA), .ALU_CTRL_W(AC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: the instruction currently sitting in EX.
    typedef struct {
        logic            valid;
        logic [RA-1:0]   rs1;
        logic [RA-1:0]   rs2;
        logic [RA-1:0]   rd;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] imm;
        logic            use_imm;
        logic            rw;
        logic            mr;
        logic [AC-1:0]   alu;
    } slot_t;

    slot_t       m;
    logic [31:0] m_stall_cnt;
    logic [31:0] m_flush_cnt;

    function automatic logic [XLEN-1:0] fwd(input logic [RA-1:0] rs, input logic [XLEN-1:0] d);
        if (bus.mem_reg_write && bus.mem_rd_addr != 0 && bus.mem_rd_addr == rs) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd_addr != 0 && bus.wb_rd_addr == rs) return bus.wb_result;
        return d;
    endfunction

    function automatic logic exp_hazard();
        return bus.id_valid && m.valid && m.mr && m.rd != 0 &&
               (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr);
    endfunction

    function automatic logic exp_ready();
        if (bus.flush) return 1'b1;
        if (bus.ex_stall) return 1'b0;
        return !exp_hazard();
    endfunction

    function automatic logic [XLEN-1:0] exp_in_b();
        return m.use_imm ? m.imm : fwd(m.rs2, m.d2);
    endfunction

    task automatic model_reset();
        m = '{default: '0};
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    // Advance one clock. The next slot is computed from the inputs present before the edge.
    task automatic step();
        slot_t nxt;
        logic  hz;
        nxt = m;
        hz  = exp_hazard();
        if (bus.flush) begin
            nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0;
            m_flush_cnt = m_flush_cnt + 1;
        end else if (bus.ex_stall) begin
            nxt = m;
        end else if (hz) begin
            nxt.valid = 1'b0;
            m_stall_cnt = m_stall_cnt + 1;
        end else if (bus.id_valid) begin
            nxt.valid = 1'b1;
            nxt.rs1 = bus.id_rs1_addr;   nxt.rs2 = bus.id_rs2_addr;
            nxt.d1 = bus.id_rs1_data;    nxt.d2 = bus.id_rs2_data;
            nxt.imm = bus.id_imm;        nxt.use_imm = bus.id_use_imm;
            nxt.rd = bus.id_rd_addr;     nxt.rw = bus.id_reg_write;
            nxt.mr = bus.id_mem_read;    nxt.alu = bus.id_alu_control;
        end else begin
            nxt.valid = 1'b0;
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    // driver tasks
    task automatic drive_idle();
        bus.id_valid = 0; bus.id_rs1_addr = 0; bus.id_rs2_addr = 0;
        bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
        bus.id_use_imm = 0; bus.id_rd_addr = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.id_alu_control = 0;
        bus.flush = 0; bus.ex_stall = 0;
        bus.mem_rd_addr = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
        bus.wb_rd_addr = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
    endtask

    task automatic drive_id(input logic [RA-1:0] rs1, input logic [RA-1:0] rs2,
                            input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                            input logic [XLEN-1:0] imm, input logic use_imm,
                            input logic [RA-1:0] rd, input logic rw, input logic mr,
                            input logic [AC-1:0] alu);
        bus.id_valid = 1; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_imm = imm;
        bus.id_use_imm = use_imm; bus.id_rd_addr = rd; bus.id_reg_write = rw;
        bus.id_mem_read = mr; bus.id_alu_control = alu;
    endtask

    task automatic do_reset();
        reset = 1;
        drive_idle();
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1;
        drive_idle();
        drive_id(5'd1, 5'd2, 32'h1234, 32'h5678, 32'h9, 1'b0, 5'd3, 1'b1, 1'b1, 4'd7);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_in_a !== 0 || bus.ex_in_b !== 0 || bus.ex_store_data !== 0 ||
            bus.ex_alu_control !== 0 || bus.ex_rd_addr !== 0 || bus.ex_reg_write !== 0 || bus.ex_mem_read !== 0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b a=%h b=%h sd=%h alu=%h rd=%h rw=%b mr=%b, required all 0",
                     bus.ex_valid, bus.ex_in_a, bus.ex_in_b, bus.ex_store_data, bus.ex_alu_control,
                     bus.ex_rd_addr, bus.ex_reg_write, bus.ex_mem_read);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bus.stall_cycles !== 0 || bus.flush_count !== 0) begin
            errors++;
            $display("FAIL reset_counters: stall=%0d flush=%0d, required 0 0", bus.stall_cycles, bus.flush_count);
        end
`endif
        reset = 0;
        model_reset();
        drive_idle();
    endtask

    task automatic test_basic();
        drive_id(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 4'd0);
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL basic_ready: got %b, required 1", bus.id_ready);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_in_a !== 32'd5 || bus.ex_in_b !== 32'd7 || bus.ex_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: valid=%b a=%0d b=%0d rw=%b, required 1 5 7 1",
                     bus.ex_valid, bus.ex_in_a, bus.ex_in_b, bus.ex_reg_write);
        end
        reset = 1;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_in_a !== 0 || bus.ex_in_b !== 0 || bus.ex_rd_addr !== 0 || bus.ex_reg_write !== 0) begin
            errors++;
            $display("FAIL async_reset: valid=%b a=%h b=%h rd=%h rw=%b, required all 0",
                     bus.ex_valid, bus.ex_in_a, bus.ex_in_b, bus.ex_rd_addr, bus.ex_reg_write);
        end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
    endtask

    task automatic test_forward();
        drive_id(5'd3, 5'd5, 32'hAA, 32'hBB, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 4'd1);
        step();
        drive_idle();
        bus.mem_rd_addr = 5'd3; bus.mem_reg_write = 1; bus.mem_result = 32'h11;
        bus.wb_rd_addr = 5'd3;  bus.wb_reg_write = 1;  bus.wb_result = 32'h22;
        #1;
        checks++;
        if (bus.ex_in_a !== 32'h11 || bus.ex_store_data !== 32'hBB) begin
            errors++; $display("FAIL fwd_mem: a=%h sd=%h, required 11 bb", bus.ex_in_a, bus.ex_store_data);
        end
        bus.mem_reg_write = 0;
        #1;
        checks++;
        if (bus.ex_in_a !== 32'h22) begin
            errors++; $display("FAIL fwd_wb: a=%h, required 22", bus.ex_in_a);
        end
        bus.wb_reg_write = 0;
        bus.mem_rd_addr = 5'd5; bus.mem_reg_write = 1; bus.mem_result = 32'h33;
        #1;
        checks++;
        if (bus.ex_in_a !== 32'hAA || bus.ex_in_b !== 32'h33 || bus.ex_store_data !== 32'h33) begin
            errors++;
            $display("FAIL fwd_rs2: a=%h b=%h sd=%h, required aa 33 33", bus.ex_in_a, bus.ex_in_b, bus.ex_store_data);
        end
        drive_idle();
    endtask

    task automatic test_zero_reg();
        drive_id(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd1, 1'b1, 1'b0, 4'd2);
        step();
        drive_idle();
        bus.mem_rd_addr = 5'd0; bus.mem_reg_write = 1; bus.mem_result = 32'hFF;
        bus.wb_rd_addr = 5'd0;  bus.wb_reg_write = 1;  bus.wb_result = 32'hEE;
        #1;
        checks++;
        if (bus.ex_in_a !== 32'd0 || bus.ex_in_b !== 32'd0 || bus.ex_store_data !== 32'd0) begin
            errors++;
            $display("FAIL zero_reg: a=%h b=%h sd=%h, required 0 0 0", bus.ex_in_a, bus.ex_in_b, bus.ex_store_data);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(5'd1, 5'd2, 32'h1, 32'h2, 32'd0, 1'b0, 5'd4, 1'b1, 1'b1, 4'd2);
        step();
        drive_id(5'd7, 5'd4, 32'h30, 32'h40, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 4'd3);
        #1;
        checks++;
        if (bus.id_ready !== 1'b0 || bus.ex_mem_read !== 1'b1) begin
            errors++; $display("FAIL lu_ready: ready=%b mr=%b, required 0 1", bus.id_ready, bus.ex_mem_read);
        end
        step();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: valid=%b rw=%b mr=%b ready=%b, required 0 0 0 1",
                     bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.id_ready);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_in_a !== 32'h30 || bus.ex_in_b !== 32'h40 || bus.ex_rd_addr !== 5'd8) begin
            errors++;
            $display("FAIL lu_accept: valid=%b a=%h b=%h rd=%0d, required 1 30 40 8",
                     bus.ex_valid, bus.ex_in_a, bus.ex_in_b, bus.ex_rd_addr);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bus.stall_cycles !== 32'd1) begin
            errors++; $display("FAIL lu_stall_cycles: got %0d, required 1", bus.stall_cycles);
        end
`endif
    endtask

    task automatic test_stall_flush();
        drive_id(5'd1, 5'd2, 32'h100, 32'h200, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 4'd5);
        step();
        drive_id(5'd3, 5'd4, 32'h300, 32'h400, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 4'd6);
        bus.ex_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.id_ready !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_in_a !== 32'h100 ||
                bus.ex_in_b !== 32'h200 || bus.ex_rd_addr !== 5'd9 || bus.ex_alu_control !== 4'd5) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ready=%b valid=%b a=%h b=%h rd=%0d alu=%0d, required 0 1 100 200 9 5",
                         i, bus.id_ready, bus.ex_valid, bus.ex_in_a, bus.ex_in_b, bus.ex_rd_addr, bus.ex_alu_control);
            end
            if (i < 3) step();
        end
        bus.flush = 1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got %b, required 1", bus.id_ready);
        end
        step();
        drive_idle();
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
            errors++; $display("FAIL flush_kill: valid=%b rw=%b, required 0 0", bus.ex_valid, bus.ex_reg_write);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bus.flush_count !== m_flush_cnt || bus.stall_cycles !== m_stall_cnt) begin
            errors++;
            $display("FAIL flush_counters: flush=%0d stall=%0d, required %0d %0d",
                     bus.flush_count, bus.stall_cycles, m_flush_cnt, m_stall_cnt);
        end
`endif
    endtask

    task automatic test_imm();
        drive_id(5'd1, 5'd2, 32'd5, 32'd9, 32'hFFFF_FFFC, 1'b1, 5'd3, 1'b1, 1'b0, 4'd0);
        step();
        drive_idle();
        #1;
        checks++;
        if (bus.ex_in_b !== 32'hFFFF_FFFC || bus.ex_store_data !== 32'd9 || bus.ex_in_a !== 32'd5) begin
            errors++;
            $display("FAIL imm_select: a=%h b=%h sd=%h, required 5 fffffffc 9",
                     bus.ex_in_a, bus.ex_in_b, bus.ex_store_data);
        end
    endtask

    task automatic test_reset_mid();
        drive_id(5'd1, 5'd2, 32'h77, 32'h88, 32'd0, 1'b0, 5'd5, 1'b1, 1'b1, 4'd4);
        step();
        bus.ex_stall = 1;
        bus.flush = 1;
        #1;
        reset = 1;
        #1;
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 || bus.ex_rd_addr !== 0 || bus.ex_in_a !== 0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b mr=%b rd=%0d a=%h, required 0 0 0 0",
                     bus.ex_valid, bus.ex_mem_read, bus.ex_rd_addr, bus.ex_in_a);
        end
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();
        drive_idle();
        drive_id(5'd1, 5'd2, 32'h55, 32'h66, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 4'd3);
        step();
        drive_idle();
        #1;
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_in_a !== 32'h55 || bus.ex_rd_addr !== 5'd7) begin
            errors++;
            $display("FAIL reset_release: valid=%b a=%h rd=%0d, required 1 55 7", bus.ex_valid, bus.ex_in_a, bus.ex_rd_addr);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            bus.id_valid       = ($urandom_range(0, 3) != 0);
            bus.id_rs1_addr    = RA'($urandom_range(0, 3));
            bus.id_rs2_addr    = RA'($urandom_range(0, 3));
            bus.id_rs1_data    = $urandom;
            bus.id_rs2_data    = $urandom;
            bus.id_imm         = $urandom;
            bus.id_use_imm     = 1'($urandom_range(0, 1));
            bus.id_rd_addr     = RA'($urandom_range(0, 3));
            bus.id_reg_write   = 1'($urandom_range(0, 1));
            bus.id_mem_read    = ($urandom_range(0, 2) == 0);
            bus.id_alu_control = AC'($urandom_range(0, 15));
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.ex_stall       = ($urandom_range(0, 4) == 0);
            bus.mem_rd_addr    = RA'($urandom_range(0, 3));
            bus.mem_reg_write  = 1'($urandom_range(0, 1));
            bus.mem_result     = $urandom;
            bus.wb_rd_addr     = RA'($urandom_range(0, 3));
            bus.wb_reg_write   = 1'($urandom_range(0, 1));
            bus.wb_result      = $urandom;
            #1;
            checks++;
            if (bus.id_ready !== exp_ready() || bus.ex_valid !== m.valid ||
                bus.ex_in_a !== fwd(m.rs1, m.d1) || bus.ex_in_b !== exp_in_b() ||
                bus.ex_store_data !== fwd(m.rs2, m.d2) || bus.ex_alu_control !== m.alu ||
                bus.ex_rd_addr !== m.rd || bus.ex_reg_write !== (m.valid & m.rw) ||
                bus.ex_mem_read !== (m.valid & m.mr)) begin
                errors++;
                $display("FAIL random[%0d]: ready=%b/%b valid=%b/%b a=%h/%h b=%h/%h sd=%h/%h rw=%b/%b mr=%b/%b (got/required)",
                         c, bus.id_ready, exp_ready(), bus.ex_valid, m.valid, bus.ex_in_a, fwd(m.rs1, m.d1),
                         bus.ex_in_b, exp_in_b(), bus.ex_store_data, fwd(m.rs2, m.d2),
                         bus.ex_reg_write, m.valid & m.rw, bus.ex_mem_read, m.valid & m.mr);
            end
`ifdef ID_EX_PERF_CNT_EN
            checks++;
            if (bus.stall_cycles !== m_stall_cnt || bus.flush_count !== m_flush_cnt) begin
                errors++;
                $display("FAIL random_cnt[%0d]: stall=%0d flush=%0d, required %0d %0d",
                         c, bus.stall_cycles, bus.flush_count, m_stall_cnt, m_flush_cnt);
            end
`endif
            step();
        end
        drive_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_forward();
        test_zero_reg();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
